// File: rtl/viterbi_acs_serial_if.sv
// rtl/viterbi_acs_serial_if.sv - step input handshake and per-state result beats for the serial ACS
interface viterbi_acs_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] rx;
    logic       frame_start;
    logic       term_in;
    logic [2:0] data_id_in;
    logic [6:0] PM_out;
    logic [1:0] addr_out;
    logic       dec_out;
    logic       term_out;
    logic [2:0] data_id_out;
    logic       data_en;

    modport slave (
        input  in_valid, rx, frame_start, term_in, data_id_in,
        output in_ready, PM_out, addr_out, dec_out, term_out, data_id_out, data_en
    );

    modport master (
        output in_valid, rx, frame_start, term_in, data_id_in,
        input  in_ready, PM_out, addr_out, dec_out, term_out, data_id_out, data_en
    );
endinterface

// File: rtl/viterbi_acs_serial.sv
// rtl/viterbi_acs_serial.sv - K=3 rate-1/2 add-compare-select, four states emitted one per cycle
module viterbi_acs_serial (
    input  logic                    PM_clk,
    input  logic                    PM_rst,
    viterbi_acs_serial_if.slave     bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [6:0] pm_q   [4];
    logic [6:0] sh_pm  [4];
    logic [3:0] sh_dec;
    logic [6:0] old_pm [4];
    logic [6:0] acs_pm [4];
    logic [6:0] new_pm [4];
    logic [3:0] acs_dec;
    logic       all_hi;
    logic       accept;

    logic [6:0] pm_out_q, pm_out_d;
    logic [1:0] addr_q, addr_d;
    logic       dec_q, dec_d;
    logic       term_q, term_d;
    logic [2:0] id_q, id_d;
    logic       en_q, en_d;

    function automatic logic [1:0] branch_bm(input logic [1:0] p, input logic u, input logic [1:0] r);
        logic [1:0] x;
        x = r ^ {u ^ p[1] ^ p[0], u ^ p[0]};
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [6:0] sat_add(input logic [6:0] m, input logic [1:0] b);
        logic [7:0] s;
        s = {1'b0, m} + {6'd0, b};
        return s[7] ? 7'd127 : s[6:0];
    endfunction

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && (state_q == IDLE);

    always_comb begin
        logic [1:0] nb;
        logic [1:0] p0;
        logic [1:0] p1;
        logic [6:0] ca;
        logic [6:0] cb;
        nb      = 2'd0;
        p0      = 2'd0;
        p1      = 2'd0;
        ca      = 7'd0;
        cb      = 7'd0;
        acs_dec = 4'd0;
        for (int i = 0; i < 4; i++) begin
            old_pm[i] = bus.frame_start ? ((i == 0) ? 7'd0 : 7'd32) : pm_q[i];
        end
        // Predecessors of n differ only in their oldest bit; u is the newest bit of n.
        for (int n = 0; n < 4; n++) begin
            nb         = 2'(n);
            p0         = {nb[0], 1'b0};
            p1         = {nb[0], 1'b1};
            ca         = sat_add(old_pm[p0], branch_bm(p0, nb[1], bus.rx));
            cb         = sat_add(old_pm[p1], branch_bm(p1, nb[1], bus.rx));
            acs_dec[n] = (cb < ca);
            acs_pm[n]  = (cb < ca) ? cb : ca;
        end
        // A metric is >= 64 exactly when bit 6 is set, so subtracting 64 clears that bit.
        all_hi = acs_pm[0][6] & acs_pm[1][6] & acs_pm[2][6] & acs_pm[3][6];
        for (int i = 0; i < 4; i++) begin
            new_pm[i] = all_hi ? {1'b0, acs_pm[i][5:0]} : acs_pm[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pm_out_d = pm_out_q;
        addr_d   = addr_q;
        dec_d    = dec_q;
        term_d   = term_q;
        id_d     = id_q;
        en_d     = en_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = EMIT;
                    cnt_d    = 2'd1;
                    pm_out_d = new_pm[0];
                    addr_d   = 2'd0;
                    dec_d    = acs_dec[0];
                    term_d   = bus.term_in;
                    id_d     = bus.data_id_in;
                    en_d     = 1'b1;
                end else begin
                    en_d = 1'b0;
                end
            end
            EMIT: begin
                pm_out_d = sh_pm[cnt_q];
                addr_d   = cnt_q;
                dec_d    = sh_dec[cnt_q];
                en_d     = 1'b1;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PM_clk or negedge PM_rst) begin
        if (!PM_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            pm_out_q <= 7'd0;
            addr_q   <= 2'd0;
            dec_q    <= 1'b0;
            term_q   <= 1'b1;
            id_q     <= 3'd0;
            en_q     <= 1'b0;
            sh_dec   <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                pm_q[i]  <= (i == 0) ? 7'd0 : 7'd32;
                sh_pm[i] <= 7'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pm_out_q <= pm_out_d;
            addr_q   <= addr_d;
            dec_q    <= dec_d;
            term_q   <= term_d;
            id_q     <= id_d;
            en_q     <= en_d;
            if (accept) begin
                sh_dec <= acs_dec;
                for (int i = 0; i < 4; i++) begin
                    pm_q[i]  <= new_pm[i];
                    sh_pm[i] <= new_pm[i];
                end
            end
        end
    end

    assign bus.PM_out      = pm_out_q;
    assign bus.addr_out    = addr_q;
    assign bus.dec_out     = dec_q;
    assign bus.term_out    = term_q;
    assign bus.data_id_out = id_q;
    assign bus.data_en     = en_q;
endmodule

// File: tb/tb_viterbi_acs_serial.sv
// tb/tb_viterbi_acs_serial.sv - scoreboard bench for viterbi_acs_serial
module tb_viterbi_acs_serial;
    logic PM_clk = 1'b0;
    logic PM_rst = 1'b0;
    always #5 PM_clk = ~PM_clk;

    viterbi_acs_serial_if bus();
    viterbi_acs_serial dut (.PM_clk(PM_clk), .PM_rst(PM_rst), .bus(bus));

    typedef struct packed {
        logic [1:0] addr;
        logic [6:0] pm;
        logic       dec;
        logic       term;
        logic [2:0] id;
    } beat_t;

    beat_t sb[$];
    int n_tests  = 0;
    int n_fail   = 0;
    int run_len  = 0;
    int last_run = 0;
    int step_min = 255;
    int m[4];

    task automatic chk(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic model_reset();
        m = '{0, 32, 32, 32};
    endtask

    // Reference: relax every (state, input bit) transition of the encoder shift register.
    task automatic send(input logic fs, input logic [1:0] r, input logic t, input logic [2:0] id,
                        input logic hold, input logic hand, input logic [27:0] hpm);
        int    old[4];
        int    best[4];
        int    dec[4];
        int    b;
        int    n, c0, c1, bm, cand;
        beat_t e;
        bus.frame_start = fs;
        bus.rx          = r;
        bus.term_in     = t;
        bus.data_id_in  = id;
        bus.in_valid    = 1'b1;
        b = 0;
        while (!bus.in_ready && b < 20) begin
            @(posedge PM_clk);
            #1;
            b++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            old[i]  = fs ? ((i == 0) ? 0 : 32) : m[i];
            best[i] = 1000;
            dec[i]  = 0;
        end
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                n    = u * 2 + (p >> 1);
                c0   = u ^ ((p >> 1) & 1) ^ (p & 1);
                c1   = u ^ (p & 1);
                bm   = (int'(r[1]) ^ c0) + (int'(r[0]) ^ c1);
                cand = old[p] + bm;
                if (cand > 127) cand = 127;
                if (cand < best[n]) begin
                    best[n] = cand;
                    dec[n]  = p & 1;
                end
            end
        end
        if (best[0] >= 64 && best[1] >= 64 && best[2] >= 64 && best[3] >= 64) begin
            for (int i = 0; i < 4; i++) best[i] -= 64;
        end
        for (int i = 0; i < 4; i++) begin
            m[i]   = best[i];
            e.addr = 2'(i);
            e.pm   = hand ? hpm[7*i +: 7] : 7'(best[i]);
            e.dec  = hand ? 1'b0 : dec[i][0];
            e.term = t;
            e.id   = id;
            sb.push_back(e);
        end
        @(posedge PM_clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    always @(negedge PM_clk) begin
        beat_t e;
        if (PM_rst) begin
            chk("in_ready_phase", int'(bus.in_ready), int'(!bus.data_en || bus.addr_out == 2'd3));
            if (bus.data_en) begin
                run_len++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got addr=%0d pm=%0d expected no beat", bus.addr_out, bus.PM_out);
                end else begin
                    e = sb.pop_front();
                    chk("addr", int'(bus.addr_out), int'(e.addr));
                    chk("pm", int'(bus.PM_out), int'(e.pm));
                    chk("dec", int'(bus.dec_out), int'(e.dec));
                    chk("term", int'(bus.term_out), int'(e.term));
                    chk("data_id", int'(bus.data_id_out), int'(e.id));
                    chk("pm_not_sat", int'(bus.PM_out != 7'd127), 1);
                    if (bus.addr_out == 2'd0) step_min = 255;
                    if (int'(bus.PM_out) < step_min) step_min = int'(bus.PM_out);
                    if (bus.addr_out == 2'd3) chk("step_min_lt_64", int'(step_min < 64), 1);
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.in_valid    = 1'b0;
        bus.rx          = 2'b00;
        bus.frame_start = 1'b0;
        bus.term_in     = 1'b0;
        bus.data_id_in  = 3'd0;
        model_reset();
        repeat (2) @(posedge PM_clk);
        #1;
        chk("rst_pm", int'(bus.PM_out), 0);
        chk("rst_addr", int'(bus.addr_out), 0);
        chk("rst_dec", int'(bus.dec_out), 0);
        chk("rst_id", int'(bus.data_id_out), 0);
        chk("rst_term", int'(bus.term_out), 1);
        chk("rst_en", int'(bus.data_en), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        PM_rst = 1'b1;
        @(posedge PM_clk);
        #1;

        send(1'b1, 2'b00, 1'b0, 3'd5, 1'b1, 1'b1, {7'd33, 7'd2, 7'd33, 7'd0});
        send(1'b0, 2'b11, 1'b0, 3'd6, 1'b0, 1'b1, {7'd3, 7'd0, 7'd3, 7'd2});
        repeat (6) @(posedge PM_clk);
        #1;
        chk("run_two_steps", last_run, 8);

        send(1'b0, 2'b01, 1'b0, 3'd1, 1'b1, 1'b0, 28'd0);
        send(1'b0, 2'b10, 1'b0, 3'd2, 1'b1, 1'b0, 28'd0);
        send(1'b0, 2'b00, 1'b0, 3'd3, 1'b0, 1'b0, 28'd0);
        repeat (6) @(posedge PM_clk);
        #1;
        chk("run_back_to_back", last_run, 12);

        send(1'b0, 2'b10, 1'b1, 3'd4, 1'b0, 1'b0, 28'd0);
        send(1'b0, 2'b01, 1'b0, 3'd4, 1'b0, 1'b0, 28'd0);

        for (int i = 0; i < 200; i++) begin
            send(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'(i),
                 1'(i % 3 != 2), 1'b0, 28'd0);
        end
        bus.in_valid = 1'b0;
        repeat (8) @(posedge PM_clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        send(1'b0, 2'b11, 1'b0, 3'd7, 1'b0, 1'b0, 28'd0);
        b = 0;
        do begin
            @(negedge PM_clk);
            b++;
        end while (!(bus.data_en && bus.addr_out == 2'd2) && b < 10);
        chk("reach_beat2", int'(bus.data_en && bus.addr_out == 2'd2), 1);
        #2;
        PM_rst = 1'b0;
        #1;
        chk("mid_rst_pm", int'(bus.PM_out), 0);
        chk("mid_rst_addr", int'(bus.addr_out), 0);
        chk("mid_rst_dec", int'(bus.dec_out), 0);
        chk("mid_rst_id", int'(bus.data_id_out), 0);
        chk("mid_rst_term", int'(bus.term_out), 1);
        chk("mid_rst_en", int'(bus.data_en), 0);
        chk("mid_rst_ready", int'(bus.in_ready), 1);
        sb.delete();
        model_reset();
        run_len = 0;
        @(posedge PM_clk);
        #1;
        PM_rst = 1'b1;
        @(posedge PM_clk);
        #1;
        send(1'b0, 2'b00, 1'b0, 3'd2, 1'b0, 1'b1, {7'd33, 7'd2, 7'd33, 7'd0});
        repeat (6) @(posedge PM_clk);
        #1;
        chk("run_after_rst", last_run, 4);
        chk("sb_drained_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/viterbi_acs_serial.md
# viterbi_acs_serial

Add-compare-select stage of the pipelined K=3, rate-1/2 hard-decision Viterbi decoder (generators g0=7, g1=5; four trellis states). It accepts one received symbol pair per trellis step and updates the four path metrics held internally. It then streams the results one state per cycle (state index, new path metric, decision bit, termination flag, data ID) into the path-metric pipeline register directly downstream. All outputs are registered so they feed that register with no combinational path.

## Interface
- No parameters. Fixed values: metric width 7, states 4, initial metrics {0,32,32,32}, normalisation threshold 64.
- PM_clk  in  1  clock, rising edge.
- PM_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  a trellis step is offered on rx/frame_start/term_in/data_id_in.
- in_ready  out  1  combinational; 1 exactly when FSM is IDLE.
- rx  in  2  hard-decision received pair; rx[1] is compared with c0 (g0), rx[0] with c1 (g1).
- frame_start  in  1  use initial metrics instead of stored metrics as the "old" metrics for this step.
- term_in  in  1  tail/termination marker for this step.
- data_id_in  in  3  frame tag.
- PM_out  out  7  new path metric of state addr_out.
- addr_out  out  2  state index of the current beat.
- dec_out  out  1  survivor decision for addr_out.
- term_out  out  1  term_in of the step, repeated on all 4 beats.
- data_id_out  out  3  data_id_in of the step, repeated on all 4 beats.
- data_en  out  1  1 while a valid beat is on the outputs.

## Operation
- State s = {u(t-1), u(t-2)}. Next state n = {u, s[1]}, with u = n[1]. The predecessors of n are p0 = {n[0],0} and p1 = {n[0],1}.
- Branch code from p to n: c0 = u^p[1]^p[0], c1 = u^p[0]. Branch metric = popcount(rx ^ {c0,c1}), range 0..2.
- Candidate metric = min(old[p] + bm, 127) (saturating). new[n] = smaller candidate. dec = 1 when p1's candidate is strictly smaller; ties select p0 (dec = 0).
- Normalisation: if all four new[n] >= 64, subtract 64 from every one. Stored and emitted metrics are the normalised values.
- On accept (in_valid & in_ready), all four new metrics and decisions are computed in the same cycle. The metric registers are updated and the results captured in a 4-entry shadow buffer.
- FSM:
  - IDLE → EMIT on accept. The output registers load beat 0 at that same edge; cnt := 1.
  - EMIT, cnt = 1..3: each edge loads beat cnt and increments cnt. The edge that loads beat 3 returns the FSM to IDLE.
  - IDLE without accept: data_en := 0 at the next edge. PM_out, addr_out, dec_out, term_out and data_id_out hold their values.
- Beats are emitted in order addr 0,1,2,3. in_valid during EMIT is ignored; no input is captured.
- frame_start is ignored unless the step is accepted.

## Timing
- Reset values: PM_out=0, addr_out=0, dec_out=0, data_id_out=0, term_out=1, data_en=0. FSM in IDLE (in_ready=1). Internal metrics = {0,32,32,32}.
- Accept edge E: beat 0 is visible from E to E+1, beat 3 from E+3 to E+4. data_en is 1 across all four.
- in_ready is high while beat 3 is displayed. An accept on that edge puts the next step's beat 0 on the outputs with no gap, giving a sustained 4-cycle period with data_en continuously 1.
- Reset asserted mid-step: the emission is aborted, outputs return immediately to reset values, metrics reinitialise, and no partial step resumes.

## Test plan
- Reset, then frame_start=1, rx=00, data_id_in=5, term_in=0 → beats (addr,PM,dec) = (0,0,0), (1,33,0), (2,2,0), (3,33,0) on 4 consecutive cycles. data_id_out=5, data_en=1 throughout, then 0.
- Directly follow with rx=11, frame_start=0 → beats (0,2,0), (1,3,0), (2,0,0), (3,3,0).
- Back-to-back: hold in_valid=1 for 3 steps → data_en high for exactly 12 consecutive cycles. addr sequence 0,1,2,3 repeated. in_ready high only on cycles showing addr 3.
- Normalisation: random rx stream of 200 steps vs. a C/Python reference model → every beat matches. The minimum PM across each step is always < 64, and PM never reaches 127.
- Decision and term check: a step with term_in=1 → term_out=1 on all 4 beats and 0 on the following step. dec_out matches the model, including cases where a tie forces dec=0.
- Assert PM_rst at beat 2 → outputs go immediately to reset values (term_out=1). After release, the frame_start=0, rx=00 step gives the same beats as the first scenario.
